// File: rtl/lfp_q6_11_pkg.sv
// Shared Q6.11 types, constants and clamp helpers for the LSTM MAC datapath.
package lfp_q6_11_pkg;

   typedef logic signed [17:0] q6_11_t;

   localparam int Q_FRAC      = 11;
   localparam int Q_ONE       = 2048;
   localparam int SAT_LIM_DEF = 16384;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } seq_state_e;

   // Symmetric clamp to +/-lim (lim given in LSB units).
   function automatic q6_11_t clamp_q6_11(input q6_11_t v, input int lim);
      q6_11_t r;
      r = v;
      if (int'(v) > lim)
         r = q6_11_t'(lim);
      else if (int'(v) < -lim)
         r = q6_11_t'(-lim);
      return r;
   endfunction

   // True when v would be altered by clamp_q6_11.
   function automatic logic out_of_range_q6_11(input q6_11_t v, input int lim);
      return (int'(v) > lim) || (int'(v) < -lim);
   endfunction

endpackage

// File: rtl/lfp_mac_seq_q6_11.sv
// Sequencer that accumulates LEN Q6.11 terms onto a bias through a shared
// external combinational adder, clamping after every add.
module lfp_mac_seq_q6_11
   import lfp_q6_11_pkg::*;
#(
   parameter int W       = 18,
   parameter int MAX_LEN = 64,
   parameter int SAT_LIM = SAT_LIM_DEF,
   localparam int LW     = $clog2(MAX_LEN + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [LW-1:0] len_cfg,
   input  logic [W-1:0]  bias_q,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [W-1:0]  s_term_q,
   output logic [W-1:0]  add_a,
   output logic [W-1:0]  add_b,
   input  logic [W-1:0]  add_sum,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [W-1:0]  m_data_q,
   output logic          sat_flag,
   output logic          busy
);

   seq_state_e    r_state;
   q6_11_t        r_acc;
   logic [LW-1:0] r_cnt;
   logic [LW-1:0] r_len;
   logic          r_sat;
   logic          r_s_ready;
   logic          r_m_valid;
   logic          r_busy;

   logic [LW-1:0] w_len;
   q6_11_t        w_bias;
   q6_11_t        w_sum;
   logic          w_beat;
   logic          w_last;

   // Oversized lengths are folded down to the largest supported vector.
   assign w_len  = (len_cfg > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len_cfg;
   assign w_bias = q6_11_t'(bias_q);
   assign w_sum  = q6_11_t'(add_sum);
   assign w_beat = r_s_ready && s_valid;
   assign w_last = (r_cnt + LW'(1)) == r_len;

   // Control FSM with registered handshake outputs, counter and accumulator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_len     <= '0;
         r_sat     <= 1'b0;
         r_s_ready <= 1'b0;
         r_m_valid <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_acc  <= clamp_q6_11(w_bias, SAT_LIM);
                  r_sat  <= out_of_range_q6_11(w_bias, SAT_LIM);
                  r_len  <= w_len;
                  r_cnt  <= '0;
                  r_busy <= 1'b1;
                  if (w_len != '0) begin
                     r_state   <= ACCUM;
                     r_s_ready <= 1'b1;
                  end else begin
                     r_state   <= DONE;
                     r_m_valid <= 1'b1;
                  end
               end
            end
            ACCUM: begin
               if (w_beat) begin
                  r_acc <= clamp_q6_11(w_sum, SAT_LIM);
                  r_sat <= r_sat | out_of_range_q6_11(w_sum, SAT_LIM);
                  r_cnt <= r_cnt + LW'(1);
                  if (w_last) begin
                     r_state   <= DONE;
                     r_s_ready <= 1'b0;
                     r_m_valid <= 1'b1;
                  end
               end
            end
            DONE: begin
               // acc is kept so m_data_q still shows the last result in IDLE.
               if (m_ready) begin
                  r_state   <= IDLE;
                  r_m_valid <= 1'b0;
                  r_busy    <= 1'b0;
               end
            end
            default: begin
               r_state   <= IDLE;
               r_s_ready <= 1'b0;
               r_m_valid <= 1'b0;
               r_busy    <= 1'b0;
            end
         endcase
      end
   end

   assign s_ready  = r_s_ready;
   assign m_valid  = r_m_valid;
   assign busy     = r_busy;
   assign sat_flag = r_sat;
   assign m_data_q = W'(r_acc);
   assign add_a    = W'(r_acc);
   assign add_b    = s_term_q;

endmodule

// File: tb/tb_lfp_mac_seq_q6_11.sv
// Scoreboard bench for the Q6.11 MAC sequencer with a behavioural adder and model.
module tb_lfp_mac_seq_q6_11;

   localparam int W       = 18;
   localparam int MAX_LEN = 64;
   localparam int LIM     = 16384;
   localparam int LW      = $clog2(MAX_LEN + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [LW-1:0] len_cfg = '0;
   logic [W-1:0]  bias_q = '0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [W-1:0]  s_term_q = '0;
   logic [W-1:0]  add_a, add_b, add_sum;
   logic          m_valid;
   logic          m_ready = 1'b1;
   logic [W-1:0]  m_data_q;
   logic          sat_flag;
   logic          busy;

   typedef struct {
      int d;
      bit sat;
   } exp_t;

   exp_t sbq[$];
   int   tq[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in for the external combinational adder (wraps to W bits).
   assign add_sum = add_a + add_b;

   lfp_mac_seq_q6_11 #(.W(W), .MAX_LEN(MAX_LEN), .SAT_LIM(LIM)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .len_cfg(len_cfg), .bias_q(bias_q),
      .s_valid(s_valid), .s_ready(s_ready), .s_term_q(s_term_q),
      .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
      .m_valid(m_valid), .m_ready(m_ready), .m_data_q(m_data_q),
      .sat_flag(sat_flag), .busy(busy)
   );

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   function automatic int clampi(input int v);
      return (v > LIM) ? LIM : ((v < -LIM) ? -LIM : v);
   endfunction

   // Reference: accumulate real sums, clamping after bias and after each add.
   function automatic exp_t model(input int bias, input int n);
      exp_t e;
      int acc;
      e.sat = (bias > LIM) || (bias < -LIM);
      acc = clampi(bias);
      for (int i = 0; i < n; i++) begin
         acc = acc + tq[i];
         if (acc > LIM || acc < -LIM) e.sat = 1'b1;
         acc = clampi(acc);
      end
      e.d = acc;
      return e;
   endfunction

   // Monitor: every completed result handshake is checked against the queue.
   always @(negedge clk) begin
      if (rst_n && m_valid && m_ready) begin
         if (sbq.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_result: got %0d expected none", $signed(m_data_q));
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("m_data_q", int'($signed(m_data_q)), e.d);
            chk("sat_flag", int'(sat_flag), int'(e.sat));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one vector from tq; gaps inserts bubbles and stray starts,
   // hold keeps m_ready low for that many cycles once m_valid rises.
   task automatic run_vec(input int bias, input int len, input bit gaps,
                          input int hold, input int exp_lat);
      int   eff, i, guard, t0, first;
      bit   take;
      exp_t e;
      eff = (len > MAX_LEN) ? MAX_LEN : len;
      e = model(bias, eff);
      sbq.push_back(e);
      m_ready  = (hold == 0);
      start    = 1'b1;
      len_cfg  = LW'(len);
      bias_q   = W'(bias);
      t0 = cyc;
      tick();
      start = 1'b0;
      i = 0;
      guard = 0;
      while (i < eff && guard < 2000) begin
         take     = !(gaps && ($urandom_range(0, 3) == 0));
         s_valid  = take;
         s_term_q = W'(tq[i]);
         if (gaps && $urandom_range(0, 4) == 0) begin
            start   = 1'b1;
            bias_q  = W'($urandom_range(0, 8191));
            len_cfg = LW'($urandom_range(0, MAX_LEN));
         end else begin
            start = 1'b0;
         end
         take = take && s_ready;
         tick();
         guard++;
         if (take) i++;
      end
      s_valid = 1'b0;
      start   = 1'b0;
      if (guard >= 2000) chk("term_timeout", guard, 0);
      guard = 0;
      while (!m_valid && guard < 200) begin
         if (eff == 0) chk("s_ready_zero_len", int'(s_ready), 0);
         tick();
         guard++;
      end
      if (!m_valid) begin
         chk("m_valid_timeout", 0, 1);
         return;
      end
      if (eff == 0) chk("s_ready_zero_len", int'(s_ready), 0);
      if (exp_lat > 0) chk("latency", cyc - t0, exp_lat);
      first = int'($signed(m_data_q));
      for (int k = 0; k < hold; k++) begin
         tick();
         chk("hold_m_valid", int'(m_valid), 1);
         chk("hold_m_data", int'($signed(m_data_q)), first);
      end
      m_ready = 1'b1;
      tick();
      chk("busy_after", int'(busy), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_s_ready"}, int'(s_ready), 0);
      chk({tag, "_m_valid"}, int'(m_valid), 0);
      chk({tag, "_m_data"}, int'($signed(m_data_q)), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_sat"}, int'(sat_flag), 0);
   endtask

   initial begin
      int n, guard;
      repeat (3) tick();
      check_reset_outputs("rst");
      rst_n = 1'b1;
      tick();
      check_reset_outputs("post_rst");

      // Basic vector: 1.0 + 1.0 - 0.5 = 1.5.
      tq = '{2048, 2048, -1024};
      run_vec(0, 3, 1'b0, 0, 4);
      // Saturating bias: 16384 + 2048 clamps to 16384, then 14336.
      tq = '{2048, -2048};
      run_vec(16384, 2, 1'b0, 0, 3);
      // Bias beyond the clamp bound.
      tq = '{100};
      run_vec(20000, 1, 1'b0, 0, 2);
      // Zero length goes straight to DONE.
      tq.delete();
      run_vec(-4096, 0, 1'b0, 0, 1);
      // Oversized length folds to MAX_LEN.
      tq.delete();
      for (int k = 0; k < MAX_LEN; k++) tq.push_back(300);
      run_vec(0, 100, 1'b0, 0, MAX_LEN + 1);
      // Negative saturation, term outside the clamp range.
      tq = '{-16384, -16384, 20000, -3};
      run_vec(-1000, 4, 1'b0, 0, 5);
      // Bubbles, stray starts and a 10-cycle backpressure window.
      for (int v = 0; v < 4; v++) begin
         tq.delete();
         n = $urandom_range(1, 12);
         for (int k = 0; k < n; k++) tq.push_back(int'($urandom_range(0, 8192)) - 4096);
         run_vec(int'($urandom_range(0, 4096)) - 2048, n, 1'b1, 10, 0);
      end

      // Reset after 2 of 5 terms: partial result is dropped.
      start = 1'b1; len_cfg = LW'(5); bias_q = W'(512);
      tick();
      start = 1'b0;
      s_valid = 1'b1; s_term_q = W'(1000);
      guard = 0;
      n = 0;
      while (n < 2 && guard < 20) begin
         if (s_ready) n++;
         tick();
         guard++;
      end
      s_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      tick();
      rst_n = 1'b1;
      tick();
      tq = '{1024};
      run_vec(0, 1, 1'b0, 0, 2);

      // Random regression.
      for (int v = 0; v < 1000; v++) begin
         tq.delete();
         n = $urandom_range(1, MAX_LEN);
         for (int k = 0; k < n; k++) tq.push_back(int'($urandom_range(0, 2 * LIM)) - LIM);
         run_vec(int'($urandom_range(0, 40000)) - 20000, n,
                 ($urandom_range(0, 9) == 0), 0, 0);
      end

      guard = 0;
      while (sbq.size() != 0 && guard < 100) begin
         tick();
         guard++;
      end
      chk("scoreboard_drained", sbq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
